register_file: RTL
==================

Name: register_file

Overview:
- LITE-16 general-purpose register file: eight 16-bit storage registers, one synchronous write port, two independent registered read ports (A and B).
- Sits between the instruction decoder and the ALU. Supplies operands to the ALU and receives writeback.
- Complements the single-register write path with the read side of the datapath: request/valid read handshake, write-to-read bypass, hardwired-zero R0.

Parameters:
- WIDTH, 16, data word width in bits
- NUM_REGS, 8, number of architectural registers
- ADDR_W, 3, register address width; must equal clog2(NUM_REGS)
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  WIDTH  write data
- ra_req  in  1  read request, port A
- ra_addr  in  ADDR_W  read address, port A
- ra_data  out  WIDTH  registered read data, port A
- ra_valid  out  1  port A data valid; one-cycle pulse per accepted request
- rb_req  in  1  read request, port B
- rb_addr  in  ADDR_W  read address, port B
- rb_data  out  WIDTH  registered read data, port B
- rb_valid  out  1  port B data valid; one-cycle pulse per accepted request

Behaviour:
- Reset (rst_n low, asynchronous):
  - All storage registers clear to 16'h0000.
  - ra_data and rb_data clear to 0.
  - ra_valid and rb_valid clear to 0 immediately, without waiting for a clock edge.
  - A request in flight when reset asserts is dropped; no valid is produced for it after reset releases.
- Write:
  - On a rising edge with we=1, mem[waddr] <= wdata.
  - With we=0, storage is unchanged.
  - With ZERO_REG=1 and waddr=0, the write is discarded.
- Read, with 1-cycle latency, independently per port (port A shown; port B identical):
  - On a rising edge with ra_req=1: ra_data <= selected value and ra_valid <= 1.
  - On a rising edge with ra_req=0: ra_valid <= 0 and ra_data holds its previous value.
  - Back-to-back requests give one valid per cycle with no bubble.
- Selected value, in priority order:
  - ZERO_REG=1 and ra_addr=0 -> 0.
  - Otherwise, if we=1 and waddr=ra_addr in the same cycle -> wdata (write-through bypass).
  - Otherwise -> mem[ra_addr].
- Simultaneous events:
  - Both ports may read the same address in the same cycle; both return identical data.
  - Both ports may read the address being written; both return the bypassed wdata.
  - No arbitration and no stall; both ports are always ready.
- Address range: addresses never exceed NUM_REGS-1 with the defaults. For non-power-of-two NUM_REGS, an out-of-range read returns 0 and an out-of-range write is ignored.
- No internal FSM beyond the per-port valid flag; there are no combinational paths from inputs to outputs.

Decomposition:
- lite16_pkg holds:
  - WORD_W = 16
  - REG_ADDR_W = 3
  - NUM_REGS = 8
  - Register index constants R0 through R7
- Sub-module regfile_read_port, instantiated twice (A and B):
  - Takes req, addr, the flattened storage vector, and the bypass signals (we, waddr, wdata).
  - Produces the registered data and valid outputs, including the bypass and zero-register mux.
- Storage array and write logic live in the top module.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle while ra_valid=1 -> ra_valid, rb_valid and both data outputs read 0 before the next edge; all registers read back 16'h0000 afterwards.
2. Basic write/read: write 16'hAABB to R3; next cycle ra_req=1, ra_addr=3 -> one cycle later ra_data=16'hAABB, ra_valid=1 for exactly one cycle; ra_data still holds 16'hAABB after the pulse.
3. Bypass: R5=16'h1234; same cycle we=1, waddr=5, wdata=16'hFFFF, rb_req=1, rb_addr=5 -> rb_data=16'hFFFF the next cycle; a later read of R5 also returns 16'hFFFF.
4. Zero register: write 16'hFFFF to R0, then read R0 on both ports -> both ra_data and rb_data are 16'h0000. Also read R0 while writing R0 in the same cycle -> 0 (zero takes priority over bypass).
5. Dual-port and back-to-back: R1=16'h0001, R2=16'h0002; ra_req held high with ra_addr=1,2,1 on consecutive cycles while rb reads 2,2,1 -> ra_data=1,2,1 and rb_data=2,2,1 with valids continuously high for 3 cycles.
6. Write disabled: we=0, waddr=4, wdata=16'hDEAD -> a subsequent read of R4 returns its prior value (0 after reset).

Source files
------------

// File: rtl/lite16_pkg.sv
// LITE-16 shared constants: word width, register address width, register
// count and symbolic register indices used by the decoder and register file.
package lite16_pkg;

    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;

    localparam logic [REG_ADDR_W-1:0] R0 = 3'd0;
    localparam logic [REG_ADDR_W-1:0] R1 = 3'd1;
    localparam logic [REG_ADDR_W-1:0] R2 = 3'd2;
    localparam logic [REG_ADDR_W-1:0] R3 = 3'd3;
    localparam logic [REG_ADDR_W-1:0] R4 = 3'd4;
    localparam logic [REG_ADDR_W-1:0] R5 = 3'd5;
    localparam logic [REG_ADDR_W-1:0] R6 = 3'd6;
    localparam logic [REG_ADDR_W-1:0] R7 = 3'd7;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port of the LITE-16 register file. Selects the
// zero register, the write-through bypass, or stored data, and registers
// the result together with a one-cycle valid pulse.
//
// Handshake: the port is always ready. A cycle with i_req=1 at a rising
// edge is an accepted request; o_valid is high for exactly the following
// cycle and o_data carries the selected value. o_data holds when idle.
module regfile_read_port
    import lite16_pkg::*;
#(
    parameter int WIDTH    = lite16_pkg::WORD_W,
    parameter int NUM_REGS = lite16_pkg::NUM_REGS,
    parameter int ADDR_W   = lite16_pkg::REG_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_req,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic [NUM_REGS*WIDTH-1:0] i_mem_flat,
    input  logic                      i_we,
    input  logic [ADDR_W-1:0]         i_waddr,
    input  logic [WIDTH-1:0]          i_wdata,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_valid
);

    // A power-of-two register count means every address is legal.
    localparam bit FULL_RANGE = ((1 << ADDR_W) == NUM_REGS);

    logic [WIDTH-1:0] w_words [NUM_REGS-1:0];
    logic             w_in_range;
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_unflat
            assign w_words[g] = i_mem_flat[g*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_in_range = FULL_RANGE || (32'(i_addr) < 32'(NUM_REGS));

    // Operand select: zero register beats bypass, bypass beats storage.
    always_comb begin
        w_sel = '0;
        if ((ZERO_REG != 0) && (i_addr == '0)) begin
            w_sel = '0;
        end else if (!w_in_range) begin
            w_sel = '0;
        end else if (i_we && (i_waddr == i_addr)) begin
            w_sel = i_wdata;
        end else begin
            w_sel = w_words[i_addr];
        end
    end

    // Output register: capture on request, pulse valid, hold data when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_req;
            if (i_req) begin
                r_data <= w_sel;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/register_file.sv
// LITE-16 general-purpose register file: storage array with one synchronous
// write port and two independent registered read ports (A and B) with
// write-through bypass and an optional hardwired-zero R0.
module register_file
    import lite16_pkg::*;
#(
    parameter int WIDTH    = lite16_pkg::WORD_W,
    parameter int NUM_REGS = lite16_pkg::NUM_REGS,
    parameter int ADDR_W   = lite16_pkg::REG_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              ra_req,
    input  logic [ADDR_W-1:0] ra_addr,
    output logic [WIDTH-1:0]  ra_data,
    output logic              ra_valid,
    input  logic              rb_req,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [WIDTH-1:0]  rb_data,
    output logic              rb_valid
);

    // ADDR_W is expected to equal clog2(NUM_REGS).
    localparam bit FULL_RANGE = ((1 << ADDR_W) == NUM_REGS);

    logic [WIDTH-1:0]          r_mem [NUM_REGS-1:0];
    logic [NUM_REGS*WIDTH-1:0] w_mem_flat;
    logic                      w_wr_ok;

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign w_mem_flat[g*WIDTH +: WIDTH] = r_mem[g];
        end
    endgenerate

    // Writes to R0 (when hardwired) and to nonexistent registers are dropped.
    assign w_wr_ok = (FULL_RANGE || (32'(waddr) < 32'(NUM_REGS)))
                  && !((ZERO_REG != 0) && (waddr == '0));

    // Storage write port; reset clears every register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we && w_wr_ok) begin
            r_mem[waddr] <= wdata;
        end
    end

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_port_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (ra_req),
        .i_addr     (ra_addr),
        .i_mem_flat (w_mem_flat),
        .i_we       (we),
        .i_waddr    (waddr),
        .i_wdata    (wdata),
        .o_data     (ra_data),
        .o_valid    (ra_valid)
    );

    regfile_read_port #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_port_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (rb_req),
        .i_addr     (rb_addr),
        .i_mem_flat (w_mem_flat),
        .i_we       (we),
        .i_waddr    (waddr),
        .i_wdata    (wdata),
        .o_data     (rb_data),
        .o_valid    (rb_valid)
    );

endmodule
